// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single memory controller slave.
// Master 0 is the loader, master 1 the core; ownership is non-preemptive with a strobe timeout.
module wb_mem_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_w,
  output logic [DW-1:0] m0_dat_r,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_w,
  output logic [DW-1:0] m1_dat_r,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [DW-1:0] s_adr,
  output logic [DW-1:0] s_dat_w,
  input  logic [DW-1:0] s_dat_r,
  input  logic          s_ack,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  logic        last_owner;
  logic [15:0] cnt;
  logic        own_stb;
  logic        tmo;

  // A coincident s_ack suppresses the timeout, so the access completes normally.
  always_comb begin
    own_stb = 1'b0;
    case (state)
      OWN0:    own_stb = m0_stb;
      OWN1:    own_stb = m1_stb;
      default: own_stb = 1'b0;
    endcase
    tmo = own_stb && !s_ack && (cnt == TMO);
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_r = '0;
    case (state)
      OWN0: begin
        s_cyc    = m0_cyc & ~tmo;
        s_stb    = m0_stb & ~tmo;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        m0_ack   = s_ack;
        m0_err   = tmo;
        m0_dat_r = s_dat_r;
      end
      OWN1: begin
        s_cyc    = m1_cyc & ~tmo;
        s_stb    = m1_stb & ~tmo;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        m1_ack   = s_ack;
        m1_err   = tmo;
        m1_dat_r = s_dat_r;
      end
      default: ;
    endcase
  end

  // grant/busy are loaded with the decode of the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && (!m1_cyc || last_owner)) begin
            state      <= OWN0;
            last_owner <= 1'b0;
            grant      <= 2'b01;
            busy       <= 1'b1;
          end else if (m1_cyc) begin
            state      <= OWN1;
            last_owner <= 1'b1;
            grant      <= 2'b10;
            busy       <= 1'b1;
          end
        end
        OWN0: begin
          if (!m0_cyc || tmo) begin
            state <= IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        end
        OWN1: begin
          if (!m1_cyc || tmo) begin
            state <= IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
      if (state == IDLE || !own_stb || s_ack)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: directed arbitration/timeout/reset scenarios,
// then two randomized masters against a latency-randomized slave and a memory model.
module tb_wb_mem_arbiter;

  localparam int DW  = 32;
  localparam int TMO = 8;

  typedef struct packed {
    logic        is_err;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we [2];
  logic [DW-1:0] m_adr [2];
  logic [DW-1:0] m_dat_w [2];
  logic [DW-1:0] m_dat_r [2];
  logic          m_ack [2];
  logic          m_err [2];
  logic          s_cyc, s_stb, s_we;
  logic [DW-1:0] s_adr, s_dat_w;
  logic [DW-1:0] s_dat_r = '0;
  logic          s_ack = 1'b0;
  logic [1:0]    grant;
  logic          busy;

  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] model_mem [128];
  logic [31:0] slave_mem [128];
  logic [31:0] tbl [10];

  int   slave_mode = 0;   // 0 latency-driven, 1 never acks, 2 ack from force_ack
  logic force_ack = 1'b0;
  int   lat_lo = 0, lat_hi = 0, lat = 0, wcnt = 0;

  wb_mem_arbiter #(.DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
    .m0_dat_w(m_dat_w[0]), .m0_dat_r(m_dat_r[0]), .m0_ack(m_ack[0]), .m0_err(m_err[0]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
    .m1_dat_w(m_dat_w[1]), .m1_dat_r(m_dat_r[1]), .m1_ack(m_ack[1]), .m1_err(m_err[1]),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #2;
  endtask

  function automatic logic [31:0] init_val(input int a);
    return 32'(a) * 32'h9E3779B1 + 32'h0000_1234;
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic issue(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[i] = 1'b1;
    m_stb[i] = 1'b1;
    m_we[i] = we;
    m_adr[i] = adr;
    m_dat_w[i] = dat;
    push(i, '{is_err: 1'b0, we: we, adr: adr, dat: dat});
  endtask

  task automatic drop(input int i);
    m_cyc[i] = 1'b0;
    m_stb[i] = 1'b0;
    m_we[i] = 1'b0;
  endtask

  // Returns once master i sees ack or err in the current sampled cycle.
  task automatic wait_ack(input int i);
    int n = 0;
    while (!(m_ack[i] || m_err[i])) begin
      smp();
      n++;
      if (n > 200) begin
        checks++;
        $display("FAIL wait_ack%0d: no response within 200 cycles, got none, expected ack", i);
        return;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic agent(input int i, input int nb);
    for (int b = 0; b < nb; b++) begin
      int len = $urandom_range(4, 1);
      tick();
      for (int k = 0; k < len; k++) begin
        if (k > 0) begin
          tick();
          if ($urandom_range(1, 0) == 1) begin
            m_stb[i] = 1'b0;
            tick();
          end
        end
        issue(i, 1'($urandom_range(1, 0)), 32'($urandom_range(15, 0)), $urandom);
        smp();
        wait_ack(i);
      end
      tick();
      drop(i);
      repeat ($urandom_range(3, 0)) tick();
    end
  endtask

  // Slave: decides its response half a cycle into each clock period.
  initial begin
    forever begin
      @(negedge clk);
      s_ack = 1'b0;
      #1;
      if (slave_mode == 2) begin
        s_dat_r = slave_mem[s_adr[6:0]];
        s_ack = force_ack;
      end else if (s_cyc && s_stb) begin
        s_dat_r = slave_mem[s_adr[6:0]];
        if (slave_mode == 0 && wcnt >= lat) begin
          s_ack = 1'b1;
          wcnt = 0;
          lat = $urandom_range(lat_hi, lat_lo);
          if (s_we) slave_mem[s_adr[6:0]] = s_dat_w;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops expected responses and updates the memory model in completion order.
  initial begin
    exp_t e;
    forever begin
      smp();
      if (mon_en) begin
        if (grant == 2'b00)
          check("idle_outputs", {s_cyc, s_stb, s_we, s_adr | s_dat_w}, '0);
        for (int i = 0; i < 2; i++) begin
          if (!grant[i])
            check($sformatf("nonowner%0d_quiet", i), {m_ack[i], m_err[i], m_dat_r[i]}, '0);
          if (m_ack[i] || m_err[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              check($sformatf("unexpected_resp%0d", i), {m_ack[i], m_err[i]}, 2'b00);
            end else begin
              e = (i == 0) ? q0.pop_front() : q1.pop_front();
              if (e.is_err) begin
                check($sformatf("err_resp%0d", i), {m_ack[i], m_err[i]}, 2'b01);
              end else begin
                check($sformatf("ack_resp%0d", i), {m_ack[i], m_err[i]}, 2'b10);
                if (e.we) model_mem[e.adr[6:0]] = e.dat;
                else check($sformatf("rd_data%0d", i), m_dat_r[i], model_mem[e.adr[6:0]]);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 128; a++) begin
      model_mem[a] = init_val(a);
      slave_mem[a] = init_val(a);
    end
    for (int a = 0; a < 10; a++) tbl[a] = 32'hC0DE_0000 + 32'(a) * 32'h0001_1111;
    for (int i = 0; i < 2; i++) begin
      drop(i);
      m_adr[i] = '0;
      m_dat_w[i] = '0;
    end

    // Reset state
    tick();
    tick();
    smp();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_slave", {s_cyc, s_stb, s_we, s_adr | s_dat_w}, '0);
    check("rst_m0", {m_ack[0], m_err[0], m_dat_r[0]}, '0);
    check("rst_m1", {m_ack[1], m_err[1], m_dat_r[1]}, '0);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // m0 alone: writes 0..9 with stb held, then reads them back
    tick();
    issue(0, 1'b1, 32'd0, tbl[0]);
    smp();
    check("t2_grant_pre", grant, 2'b00);
    smp();
    check("t2_grant", grant, 2'b01);
    check("t2_busy", busy, 1'b1);
    wait_ack(0);
    for (int a = 1; a < 20; a++) begin
      tick();
      issue(0, a < 10, 32'(a % 10), (a < 10) ? tbl[a] : 32'h0);
      smp();
      wait_ack(0);
      check("t2_own", grant, 2'b01);
    end
    tick();
    drop(0);

    // Simultaneous request after reset: master 0 wins the first tie
    do_reset();
    tick();
    issue(0, 1'b1, 32'd20, 32'hAAAA_0020);
    issue(1, 1'b1, 32'd21, 32'hBBBB_0021);
    smp();
    check("t3_grant_pre", grant, 2'b00);
    smp();
    check("t3_tie", grant, 2'b01);
    wait_ack(0);
    tick();
    drop(0);
    smp();
    check("t3_hold", grant, 2'b01);
    smp();
    check("t3_gap", grant, 2'b00);
    smp();
    check("t3_m1", grant, 2'b10);
    wait_ack(1);
    tick();
    drop(1);

    // m1 burst of 4 with stb toggling; m0 requests mid-burst and must wait
    lat_lo = 1; lat_hi = 1; lat = 1;
    tick();
    issue(1, 1'b1, 32'd30, 32'h3000_0000);
    smp();
    wait_ack(1);
    check("t4_burst0", grant, 2'b10);
    for (int k = 1; k < 4; k++) begin
      tick();
      m_stb[1] = 1'b0;
      if (k == 1) issue(0, 1'b1, 32'd40, 32'h4000_0040);
      tick();
      issue(1, 1'b1, 32'(30 + k), 32'h3000_0000 + 32'(k));
      smp();
      wait_ack(1);
      check("t4_burst", grant, 2'b10);
    end
    tick();
    drop(1);
    smp();
    check("t4_hold", grant, 2'b10);
    smp();
    check("t4_gap", grant, 2'b00);
    smp();
    check("t4_m0", grant, 2'b01);
    wait_ack(0);
    tick();
    drop(0);
    lat_lo = 0; lat_hi = 0; lat = 0;

    // Silent slave: error on the 9th cycle after strobe, bus released
    slave_mode = 1;
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'd50;
    push(0, '{is_err: 1'b1, we: 1'b0, adr: 32'd50, dat: 32'h0});
    smp();
    for (int n = 1; n <= 9; n++) begin
      smp();
      if (n < 9) begin
        check("t5_no_err", m_err[0], 1'b0);
      end else begin
        check("t5_err", m_err[0], 1'b1);
        check("t5_sforce", {s_cyc, s_stb}, 2'b00);
        check("t5_grant", grant, 2'b01);
      end
    end
    tick();
    drop(0);
    smp();
    check("t5_release", grant, 2'b00);

    // Ack coincident with counter==TIMEOUT: ack wins, ownership retained
    slave_mode = 2;
    tick();
    issue(1, 1'b0, 32'd60, 32'h0);
    smp();
    repeat (8) smp();
    force_ack = 1'b1;
    smp();
    check("t6_ack_wins", {m_ack[1], m_err[1]}, 2'b10);
    force_ack = 1'b0;
    smp();
    check("t6_keep", grant, 2'b10);
    check("t6_no_err", m_err[1], 1'b0);
    tick();
    drop(1);
    slave_mode = 1;

    // Reset during an m1 read aborts it silently; next tie goes to m0
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'd10;
    smp();
    smp();
    check("t7_grant", grant, 2'b10);
    tick();
    reset = 1'b1;
    tick();
    smp();
    check("t7_rst_grant", grant, 2'b00);
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_scyc", {s_cyc, s_stb}, 2'b00);
    check("t7_rst_m1", {m_ack[1], m_err[1]}, 2'b00);
    tick();
    reset = 1'b0;
    drop(1);
    slave_mode = 0;
    tick();
    issue(0, 1'b1, 32'd70, 32'h7000_0070);
    issue(1, 1'b1, 32'd71, 32'h7100_0071);
    smp();
    smp();
    check("t7_tie", grant, 2'b01);
    wait_ack(0);
    tick();
    drop(0);
    smp();
    wait_ack(1);
    tick();
    drop(1);

    // Randomized concurrent traffic
    do_reset();
    lat_lo = 0; lat_hi = 3;
    fork
      agent(0, 20);
      agent(1, 20);
    join
    repeat (5) tick();
    check("queues_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
